cache_ctrl_assoc: RTL and testbench
===================================

# cache_ctrl_assoc

Parametrised cache controller FSM for the set-associative, multi-word-line cache. It sits between the CPU memory stage and the banked four-bank main memory, beside the tag/data arrays. It sequences hit completion, multi-word dirty write-back, pipelined line fill and final install/merge of the request. Generalisations: way count, line length and memory latency are parameters; victim selection is per-set; memory issue is a stall-aware handshake.

## Interface
Parameters:
- WAYS, 2: associativity, 1 or 2.
- WORDS, 4: words per line, power of two, 2..8. OFFW = clog2(WORDS).
- MEM_LAT, 2: cycles from accepted mem_rd to its data being valid, ≥1.
- SETS, 256: sets per way. IDXW = clog2(SETS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req_rd, req_wr  in  1  CPU request; held stable until done.
- index  in  IDXW  set index of the request.
- hit, valid, dirty  in  WAYS  per-way tag match / valid / dirty of the addressed set.
- cache_err, mem_err  in  1  array / memory error.
- mem_stall  in  1  memory cannot accept a request this cycle.
- comp  out  1  array compare mode (0 = raw access).
- cache_wr  out  1  array write enable.
- way_en  out  WAYS  one-hot way select.
- word_sel  out  OFFW  array word offset during WB/fill.
- fill_sel  out  1  array write data taken from memory.
- mem_rd, mem_wr  out  1  memory request, only with mem_stall=0.
- mem_word  out  OFFW  memory word offset.
- stall, done, cache_hit, err  out  1  CPU status.

## Operation
- States: IDLE, HIT, WB, FILL, INSTALL, DONE, ERR. All outputs are 0 in IDLE with no request. Reset forces IDLE and clears counters, the in-flight shift register and victim state.
- IDLE with a request: comp=1, cache_wr=req_wr, way_en=hit&valid.
  - Any way with hit&valid → HIT.
  - Otherwise latch a victim: the lowest invalid way, else the replacement choice. Go to WB if the victim is valid&dirty, else FILL.
- HIT: done=1, cache_hit=1 → IDLE.
- WB: comp=0, way_en=victim, word_sel=mem_word=wb_cnt, mem_wr=!mem_stall.
  - wb_cnt advances only on accepted writes.
  - After WORDS accepted writes → FILL.
- FILL: mem_rd=!mem_stall, mem_word=iss_cnt, stall=1.
  - Accepted reads push a 1 into a MEM_LAT-deep shift register.
  - When a 1 exits: cache_wr=1, comp=0, fill_sel=1, way_en=victim, word_sel=ret_cnt, and ret_cnt increments.
  - Issue and return overlap.
  - When ret_cnt reaches WORDS → INSTALL.
- INSTALL: comp=1, way_en=victim, cache_wr=req_wr (a store merges into the filled line) → DONE.
- DONE: done=1, cache_hit=0; update replacement state → IDLE.
- stall=1 in WB, FILL, INSTALL; 0 elsewhere.
- Errors:
  - req_rd&req_wr in IDLE, or cache_err or mem_err in any state, → ERR. In-flight reads are dropped.
  - ERR: err=1, done=1 for one cycle → IDLE.
- WAYS=1: victim is always way 0 and replacement logic is absent.

## Timing
- Request cycle is cycle 0.
- Hit: done at cycle 1.
- Clean miss, no stalls: FILL occupies cycles 1..WORDS+MEM_LAT, INSTALL at WORDS+MEM_LAT+1, done at WORDS+MEM_LAT+2. Defaults: done at cycle 8.
- Dirty miss: add WORDS cycles (defaults: done at 12).
- Each mem_stall cycle during issue adds one cycle. Returns stay exactly MEM_LAT after acceptance.
- Reset mid-miss: outputs 0 immediately (asynchronous); the next request starts fresh.

## Configuration
- CACHE_LRU_EN defined (WAYS=2):
  - Per-set LRU bit array, SETS×1, cleared on reset.
  - A hit in way w, or completion of a miss filling w, sets LRU[index] to the other way.
  - The replacement choice is LRU[index].
- CACHE_LRU_EN undefined:
  - A single victim flop chooses the way; it toggles at every miss DONE.
  - index is ignored.

## Test plan
- Hit: defaults, hit=2'b10, valid=2'b11, req_rd → way_en=2'b10 at cycle 0; done=cache_hit=1 at cycle 1; stall never 1.
- Clean read miss: valid=2'b01, no stalls → victim way 1; mem_rd at cycles 1–4 with words 0–3; fill writes at cycles 3–6; done=1, cache_hit=0 at cycle 8.
- Dirty write miss:
  - Setup: both ways valid, LRU way 0 dirty, req_wr.
  - Expect mem_wr words 0–3 at cycles 1–4, fill at 5–8.
  - Expect INSTALL with cache_wr=1, comp=1 at cycle 11 and done at cycle 12.
- Memory back-pressure: mem_stall high during the second issue cycle of a fill → mem_rd=0 that cycle, word 1 reissued next cycle, done one cycle later.
- Errors:
  - mem_err pulsed mid-FILL → err=done=1 next cycle, then IDLE with no mem_rd.
  - req_rd&req_wr together in IDLE → err=1 at cycle 1.
- LRU, with CACHE_LRU_EN: two misses to the same index fill way 0 then way 1. A hit on way 0 followed by a miss evicts way 1. Without the macro, victims alternate.

Source files
------------

// File: rtl/cache_ctrl_assoc.sv
// Set-associative, multi-word-line cache controller: hit completion, dirty write-back, pipelined fill, install.
// Define CACHE_LRU_EN (WAYS=2) for per-set LRU replacement; otherwise a single toggling victim flop is used.
module cache_ctrl_assoc #(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    parameter int SETS    = 256,
    localparam int OFFW   = $clog2(WORDS),
    localparam int IDXW   = $clog2(SETS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_rd,
    input  logic            req_wr,
    input  logic [IDXW-1:0] index,
    input  logic [WAYS-1:0] hit,
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] dirty,
    input  logic            cache_err,
    input  logic            mem_err,
    input  logic            mem_stall,
    output logic            comp,
    output logic            cache_wr,
    output logic [WAYS-1:0] way_en,
    output logic [OFFW-1:0] word_sel,
    output logic            fill_sel,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [OFFW-1:0] mem_word,
    output logic            stall,
    output logic            done,
    output logic            cache_hit,
    output logic            err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HIT     = 3'd1,
        ST_WB      = 3'd2,
        ST_FILL    = 3'd3,
        ST_INSTALL = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    function automatic logic [WAYS-1:0] way_onehot(input logic v);
        logic [WAYS-1:0] oh;
        for (int w = 0; w < WAYS; w++) begin
            oh[w] = (v == 1'(w));
        end
        return oh;
    endfunction

    state_t             state_r;
    logic [OFFW-1:0]    wb_cnt_r;
    logic [OFFW-1:0]    ret_cnt_r;
    logic [OFFW:0]      iss_cnt_r;
    logic [MEM_LAT-1:0] inflight_r;
    logic [MEM_LAT:0]   inflight_shift_s;
    logic               vic_r;
    logic               vic_s;
    logic               repl_s;
    logic               vic_dirty_s;
    logic [WAYS-1:0]    vic_oh_s;
    logic [WAYS-1:0]    hv_s;
    logic               req_s;
    logic               conflict_s;
    logic               err_in_s;
    logic               hit_any_s;
    logic               rd_acc_s;
    logic               wr_acc_s;
    logic               ret_s;
    logic               miss_upd_s;

    assign req_s            = req_rd | req_wr;
    assign conflict_s       = req_rd & req_wr;
    assign err_in_s         = cache_err | mem_err;
    assign hv_s             = hit & valid;
    assign hit_any_s        = |hv_s;
    assign vic_oh_s         = way_onehot(vic_r);
    assign vic_dirty_s      = |(way_onehot(vic_s) & valid & dirty);
    assign rd_acc_s         = (state_r == ST_FILL) && !iss_cnt_r[OFFW] && !mem_stall;
    assign wr_acc_s         = (state_r == ST_WB) && !mem_stall;
    assign ret_s            = (state_r == ST_FILL) && inflight_r[MEM_LAT-1];
    assign inflight_shift_s = {inflight_r, rd_acc_s};
    assign miss_upd_s       = (state_r == ST_DONE) && !err_in_s;

    // Victim choice: lowest invalid way wins, otherwise the replacement pick.
    always_comb begin
        vic_s = repl_s;
        for (int w = WAYS - 1; w >= 0; w--) begin
            vic_s = valid[w] ? vic_s : 1'(w);
        end
    end

`ifdef CACHE_LRU_EN
    logic [SETS-1:0] lru_r;
    logic            hit_upd_s;

    assign hit_upd_s = (state_r == ST_IDLE) && req_s && !conflict_s && !err_in_s && hit_any_s;
    assign repl_s    = (WAYS == 2) ? lru_r[index] : 1'b0;

    // Per-set LRU bit names the way to evict next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_r <= {SETS{1'b0}};
        end else if (hit_upd_s) begin
            lru_r[index] <= hv_s[0];
        end else if (miss_upd_s) begin
            lru_r[index] <= ~vic_r;
        end
    end
`else
    logic flip_r;
    logic unused_index_s;

    assign unused_index_s = ^index;
    assign repl_s         = (WAYS == 2) ? flip_r : 1'b0;

    // Global victim flop alternates after every completed miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_r <= 1'b0;
        end else if (miss_upd_s) begin
            flip_r <= ~flip_r;
        end
    end
`endif

    // Sequencing state, beat counters and the in-flight read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wb_cnt_r   <= {OFFW{1'b0}};
            ret_cnt_r  <= {OFFW{1'b0}};
            iss_cnt_r  <= {(OFFW+1){1'b0}};
            inflight_r <= {MEM_LAT{1'b0}};
            vic_r      <= 1'b0;
        end else if (err_in_s || (state_r == ST_IDLE && conflict_s)) begin
            state_r    <= ST_ERR;
            wb_cnt_r   <= {OFFW{1'b0}};
            ret_cnt_r  <= {OFFW{1'b0}};
            iss_cnt_r  <= {(OFFW+1){1'b0}};
            inflight_r <= {MEM_LAT{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wb_cnt_r   <= {OFFW{1'b0}};
                    ret_cnt_r  <= {OFFW{1'b0}};
                    iss_cnt_r  <= {(OFFW+1){1'b0}};
                    inflight_r <= {MEM_LAT{1'b0}};
                    if (req_s) begin
                        if (hit_any_s) begin
                            state_r <= ST_HIT;
                        end else begin
                            vic_r   <= vic_s;
                            state_r <= vic_dirty_s ? ST_WB : ST_FILL;
                        end
                    end
                end
                ST_HIT: state_r <= ST_IDLE;
                ST_WB: begin
                    if (wr_acc_s) begin
                        wb_cnt_r <= wb_cnt_r + 1'b1;
                        if (wb_cnt_r == OFFW'(WORDS - 1)) state_r <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    inflight_r <= inflight_shift_s[MEM_LAT-1:0];
                    if (rd_acc_s) iss_cnt_r <= iss_cnt_r + 1'b1;
                    if (ret_s) begin
                        ret_cnt_r <= ret_cnt_r + 1'b1;
                        if (ret_cnt_r == OFFW'(WORDS - 1)) state_r <= ST_INSTALL;
                    end
                end
                ST_INSTALL: state_r <= ST_DONE;
                ST_DONE:    state_r <= ST_IDLE;
                ST_ERR:     state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    // Output decode; reset blanks everything without waiting for a clock.
    always_comb begin
        comp      = 1'b0;
        cache_wr  = 1'b0;
        way_en    = {WAYS{1'b0}};
        word_sel  = {OFFW{1'b0}};
        fill_sel  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_word  = {OFFW{1'b0}};
        stall     = 1'b0;
        done      = 1'b0;
        cache_hit = 1'b0;
        err       = 1'b0;
        if (rst_n) begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s && !conflict_s) begin
                        comp     = 1'b1;
                        cache_wr = req_wr;
                        way_en   = hv_s;
                    end else begin
                        comp = 1'b0;
                    end
                end
                ST_HIT: begin
                    done      = 1'b1;
                    cache_hit = 1'b1;
                end
                ST_WB: begin
                    way_en   = vic_oh_s;
                    word_sel = wb_cnt_r;
                    mem_word = wb_cnt_r;
                    mem_wr   = !mem_stall;
                    stall    = 1'b1;
                end
                ST_FILL: begin
                    stall    = 1'b1;
                    mem_rd   = !iss_cnt_r[OFFW] && !mem_stall;
                    mem_word = iss_cnt_r[OFFW-1:0];
                    if (ret_s) begin
                        cache_wr = 1'b1;
                        fill_sel = 1'b1;
                        way_en   = vic_oh_s;
                        word_sel = ret_cnt_r;
                    end else begin
                        fill_sel = 1'b0;
                    end
                end
                ST_INSTALL: begin
                    comp     = 1'b1;
                    way_en   = vic_oh_s;
                    cache_wr = req_wr;
                    stall    = 1'b1;
                end
                ST_DONE: done = 1'b1;
                ST_ERR: begin
                    err  = 1'b1;
                    done = 1'b1;
                end
                default: done = 1'b0;
            endcase
        end else begin
            done = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Scoreboard bench for cache_ctrl_assoc: a transaction-level model predicts timed output events,
// a monitor pops and compares each event the DUT shows.
module tb_cache_ctrl_assoc;
    localparam int WAYS = 2, WORDS = 4, MEM_LAT = 2, SETS = 256;
    localparam int OFFW = $clog2(WORDS), IDXW = $clog2(SETS);
    localparam int K_CMP = 0, K_MWR = 1, K_MRD = 2, K_FW = 3, K_DONE = 4;

    typedef struct {
        int cyc;
        int kind;
        int word;
        int way;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_rd = 1'b0, req_wr = 1'b0;
    logic [IDXW-1:0] index = '0;
    logic [WAYS-1:0] hit = '0, valid = '0, dirty = '0;
    logic cache_err = 1'b0, mem_err = 1'b0, mem_stall = 1'b0;
    logic comp, cache_wr, fill_sel, mem_rd, mem_wr, stall, done, cache_hit, err;
    logic [WAYS-1:0] way_en;
    logic [OFFW-1:0] word_sel, mem_word;
    logic [14:0] outs;

    int vectors = 0, miscompares = 0;
    int cyc = 0, t0 = 0, stall_cnt = 0;
    ev_t exp_q[$];
    ev_t mq[$];
    bit lru_m [SETS];
    bit flip_m = 1'b0;
    int m_done, m_vic;
    bit m_miss;

    cache_ctrl_assoc #(.WAYS(WAYS), .WORDS(WORDS), .MEM_LAT(MEM_LAT), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr), .index(index),
        .hit(hit), .valid(valid), .dirty(dirty), .cache_err(cache_err), .mem_err(mem_err),
        .mem_stall(mem_stall), .comp(comp), .cache_wr(cache_wr), .way_en(way_en),
        .word_sel(word_sel), .fill_sel(fill_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_word(mem_word), .stall(stall), .done(done), .cache_hit(cache_hit), .err(err)
    );

    assign outs = {comp, cache_wr, way_en, word_sel, fill_sel, mem_rd, mem_wr, mem_word,
                   stall, done, cache_hit, err};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(int c, int k, int w, int wy, int d);
        ev_t e;
        e.cyc = c; e.kind = k; e.word = w; e.way = wy; e.data = d;
        return e;
    endfunction

    // Events are kept ordered by cycle, then by fixed kind order within a cycle.
    function automatic void ins(ev_t e);
        int i = 0;
        while (i < mq.size() && (mq[i].cyc * 8 + mq[i].kind) <= (e.cyc * 8 + e.kind)) i++;
        mq.insert(i, e);
    endfunction

    function automatic bit stall_at(logic [63:0] sm, int c);
        return (c < 64) ? sm[c] : 1'b0;
    endfunction

    function automatic bit repl_pick(int idx);
`ifdef CACHE_LRU_EN
        return lru_m[idx];
`else
        return flip_m;
`endif
    endfunction

    // Transaction-level timing model: walks issue slots, skipping stalled ones.
    task automatic model(input bit rd, input bit wr, input int idx, input logic [1:0] hv,
                         input logic [1:0] vl, input logic [1:0] dt, input logic [63:0] sm);
        logic [1:0] hvv;
        int c, i, last, way;
        mq.delete();
        m_miss = 1'b0;
        m_vic = 0;
        if (rd && wr) begin
            ins(mk(1, K_DONE, 0, 0, 2));
            m_done = 1;
            return;
        end
        hvv = hv & vl;
        ins(mk(0, K_CMP, 0, int'(hvv), int'(wr)));
        if (hvv != 2'b00) begin
            ins(mk(1, K_DONE, 0, 0, 1));
            m_done = 1;
            return;
        end
        m_miss = 1'b1;
        if (!vl[0]) m_vic = 0;
        else if (!vl[1]) m_vic = 1;
        else m_vic = int'(repl_pick(idx));
        way = 1 << m_vic;
        c = 1;
        if (vl[m_vic] && dt[m_vic]) begin
            for (int w = 0; w < WORDS; w++) begin
                while (stall_at(sm, c)) c++;
                ins(mk(c, K_MWR, w, way, w));
                c++;
            end
        end
        i = 0;
        last = 0;
        while (i < WORDS) begin
            if (!stall_at(sm, c)) begin
                ins(mk(c, K_MRD, i, 0, 0));
                ins(mk(c + MEM_LAT, K_FW, i, way, 2));
                last = c + MEM_LAT;
                i++;
            end
            c++;
        end
        ins(mk(last + 1, K_CMP, 0, way, int'(wr)));
        m_done = last + 2;
        ins(mk(m_done, K_DONE, m_done - 1, 0, 0));
    endtask

    function automatic void clear_model();
        for (int s = 0; s < SETS; s++) lru_m[s] = 1'b0;
        flip_m = 1'b0;
    endfunction

    function automatic void chk(ev_t o);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d word=%0d way=%0d data=%0d, required no event",
                     o.kind, o.cyc, o.word, o.way, o.data);
        end else begin
            e = exp_q.pop_front();
            if (o.cyc != e.cyc || o.kind != e.kind || o.word != e.word || o.way != e.way || o.data != e.data) begin
                miscompares++;
                $display("FAIL event: got kind=%0d cyc=%0d word=%0d way=%0d data=%0d, required kind=%0d cyc=%0d word=%0d way=%0d data=%0d",
                         o.kind, o.cyc, o.word, o.way, o.data, e.kind, e.cyc, e.word, e.way, e.data);
            end
        end
    endfunction

    // Monitor: turns visible DUT activity into events and checks them against the queue.
    initial begin
        int rel;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_cnt = 0;
            end else begin
                rel = cyc - t0;
                if (comp && !fill_sel) chk(mk(rel, K_CMP, 0, int'(way_en), int'(cache_wr)));
                if (mem_wr) chk(mk(rel, K_MWR, int'(mem_word), int'(way_en), int'(word_sel)));
                if (mem_rd) chk(mk(rel, K_MRD, int'(mem_word), 0, 0));
                if (fill_sel) chk(mk(rel, K_FW, int'(word_sel), int'(way_en), int'({cache_wr, comp})));
                if (stall) stall_cnt++;
                if (done) begin
                    chk(mk(rel, K_DONE, stall_cnt, 0, int'({err, cache_hit})));
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic drop_inputs();
        req_rd = 1'b0; req_wr = 1'b0; mem_stall = 1'b0; mem_err = 1'b0; cache_err = 1'b0;
    endtask

    task automatic run_txn(input bit rd, input bit wr, input int idx, input logic [1:0] hv,
                           input logic [1:0] vl, input logic [1:0] dt, input logic [63:0] sm,
                           input int err_k, input bit use_cerr, input int rst_k);
        bit finished = 1'b0;
        model(rd, wr, idx, hv, vl, dt, sm);
        foreach (mq[j]) begin
            if (err_k > 0 && mq[j].cyc > err_k) continue;
            if (rst_k > 0 && mq[j].cyc >= rst_k) continue;
            exp_q.push_back(mq[j]);
        end
        if (err_k > 0) exp_q.push_back(mk(err_k + 1, K_DONE, err_k, 0, 2));
        @(posedge clk); #1;
        t0 = cyc;
        req_rd = rd; req_wr = wr; index = IDXW'(idx); hit = hv; valid = vl; dirty = dt;
        mem_stall = sm[0]; mem_err = 1'b0; cache_err = 1'b0;
        for (int n = 1; n < 200 && !finished; n++) begin
            @(posedge clk); #1;
            if (n == rst_k) begin
                rst_n = 1'b0;
                #1;
                vectors++;
                if (outs != 15'd0) begin
                    miscompares++;
                    $display("FAIL reset_mid_miss_outputs: got %h, required 0", outs);
                end
                drop_inputs();
                @(posedge clk); #1;
                rst_n = 1'b1;
                clear_model();
                finished = 1'b1;
            end else begin
                mem_stall = stall_at(sm, n);
                if (use_cerr) cache_err = (n == err_k);
                else mem_err = (n == err_k);
                if (done) begin
                    @(posedge clk); #1;
                    drop_inputs();
                    finished = 1'b1;
                end
            end
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no done within 200 cycles, required done at cycle %0d", m_done);
            drop_inputs();
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            clear_model();
            exp_q.delete();
        end else if (err_k < 0 && rst_k < 0 && !(rd && wr)) begin
`ifdef CACHE_LRU_EN
            if (m_miss) lru_m[idx] = (m_vic == 0);
            else lru_m[idx] = hv[0] & vl[0];
`else
            if (m_miss) flip_m = ~flip_m;
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_events: got %0d events left, required 0 (next kind=%0d cyc=%0d)",
                     exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [63:0] sm;
        logic [1:0] hv, vl, dt;
        int r, ek, rk, idx;
        bit ce;
        clear_model();
        req_rd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (outs != 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        req_rd = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);

        run_txn(1, 0, 5,  2'b10, 2'b11, 2'b00, 64'd0, -1, 0, -1);       // hit way 1
        run_txn(1, 0, 7,  2'b00, 2'b01, 2'b00, 64'd0, -1, 0, -1);       // clean miss into way 1
        run_txn(0, 1, 9,  2'b00, 2'b11, 2'b11, 64'd0, -1, 0, -1);       // dirty write miss
        run_txn(1, 0, 11, 2'b00, 2'b01, 2'b00, 64'h4, -1, 0, -1);       // stall on 2nd issue
        run_txn(1, 0, 13, 2'b00, 2'b00, 2'b00, 64'd0, 3, 0, -1);        // mem_err mid-fill
        run_txn(1, 1, 15, 2'b00, 2'b11, 2'b00, 64'd0, -1, 0, -1);       // conflicting request
        run_txn(1, 0, 20, 2'b00, 2'b00, 2'b00, 64'd0, -1, 0, -1);       // fills way 0
        run_txn(1, 0, 20, 2'b00, 2'b01, 2'b00, 64'd0, -1, 0, -1);       // fills way 1
        run_txn(1, 0, 20, 2'b01, 2'b11, 2'b00, 64'd0, -1, 0, -1);       // hit way 0
        run_txn(0, 1, 20, 2'b00, 2'b11, 2'b00, 64'd0, -1, 0, -1);       // replacement miss
        run_txn(0, 1, 22, 2'b00, 2'b11, 2'b11, 64'd0, -1, 0, 4);        // reset mid write-back

        for (int t = 0; t < 200; t++) begin
            r = int'($urandom_range(0, 99));
            idx = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: hv = 2'b01;
                1: hv = 2'b10;
                default: hv = 2'b00;
            endcase
            vl = 2'($urandom_range(0, 3));
            dt = 2'($urandom_range(0, 3));
            for (int b = 0; b < 64; b++) sm[b] = ($urandom_range(0, 3) == 0);
            ek = -1; rk = -1; ce = 1'($urandom_range(0, 1));
            if (r < 6) begin
                run_txn(1, 1, idx, hv, vl, dt, sm, -1, 0, -1);
            end else begin
                r = int'($urandom_range(0, 99));
                model(r[0], ~r[0], idx, hv, vl, dt, sm);
                if (m_miss && r < 10) ek = int'($urandom_range(1, m_done - 1));
                else if (m_miss && r < 14) rk = int'($urandom_range(1, m_done - 1));
                run_txn(r[0], ~r[0], idx, hv, vl, dt, sm, ek, ce, rk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
